// File: rtl/ring_buffer_uart_tx_if.sv
// Read-side handshake between the ring buffer and its serial transmitter.
// The transmitter is the master: it issues the request and consumes ack/data.
interface ring_buffer_uart_tx_if #(
    parameter int WordSize = 8
);
    logic                dataReadEnable;
    logic                dataReadAck;
    logic [WordSize-1:0] dataRead;

    modport master (
        output dataReadEnable,
        input  dataReadAck,
        input  dataRead
    );

    modport slave (
        input  dataReadEnable,
        output dataReadAck,
        output dataRead
    );
endinterface

// File: rtl/ring_buffer_uart_tx.sv
// Drains the ring buffer one word at a time and shifts each word out as an
// asynchronous serial frame (start, WordSize data bits LSB first, stop bits).
module ring_buffer_uart_tx #(
    parameter int WordSize     = 8,
    parameter int ClocksPerBit = 16,
    parameter int StopBits     = 1,
    parameter int RetryDelay   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    ring_buffer_uart_tx_if.master       rd,
    output logic                        txOut,
    output logic                        busy,
    output logic [15:0]                 wordCount
);
    localparam int BAUD_W  = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
    localparam int BIT_W   = $clog2(WordSize + 1);
    localparam int RETRY_W = (RetryDelay > 1) ? $clog2(RetryDelay) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        RETRY,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [WordSize-1:0]  shift;
    logic                 baud_done;
    logic                 frame_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_done  = (baud_cnt == BAUD_W'(ClocksPerBit - 1));
        frame_done = 1'b0;
        case (state)
            IDLE:     if (enable) state_next = REQ;
            REQ:      state_next = WAIT_ACK;
            WAIT_ACK: state_next = rd.dataReadAck ? START : RETRY;
            RETRY: begin
                if (retry_cnt == RETRY_W'(RetryDelay - 1)) begin
                    state_next = enable ? REQ : IDLE;
                end
            end
            START:    if (baud_done) state_next = DATA;
            DATA: begin
                if (baud_done && (bit_cnt == BIT_W'(WordSize - 1))) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_done && (bit_cnt == BIT_W'(StopBits - 1))) begin
                    frame_done = 1'b1;
                    state_next = enable ? REQ : IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // Every counter restarts from zero on any state change, so each state
    // only has to know how long it lasts, never where it was entered from.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            retry_cnt <= '0;
            shift     <= '0;
            wordCount <= '0;
        end else begin
            if (state_next != state) begin
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                retry_cnt <= '0;
            end else begin
                if (state == RETRY) begin
                    retry_cnt <= retry_cnt + 1'b1;
                end
                if ((state == START) || (state == DATA) || (state == STOP)) begin
                    baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
                    if (baud_done && (state != START)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
            if ((state == WAIT_ACK) && rd.dataReadAck) begin
                shift <= rd.dataRead;
            end else if ((state == DATA) && baud_done) begin
                shift <= shift >> 1;
            end
            if (frame_done) begin
                wordCount <= wordCount + 16'd1;
            end
        end
    end

    assign rd.dataReadEnable = (state == REQ);
    assign busy              = (state == START) || (state == DATA) || (state == STOP);
    assign txOut             = (state == START) ? 1'b0 :
                               (state == DATA)  ? shift[0] : 1'b1;
endmodule

// File: tb/tb_ring_buffer_uart_tx.sv
// Scoreboard bench: words loaded into the buffer model are queued as expected
// frames, and a line monitor decodes txOut and compares every bit cycle.
module tb_ring_buffer_uart_tx;
    localparam int WordSize     = 8;
    localparam int ClocksPerBit = 4;
    localparam int StopBits     = 1;
    localparam int RetryDelay   = 4;
    localparam int FrameLen     = (1 + WordSize + StopBits) * ClocksPerBit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        txOut;
    logic        busy;
    logic [15:0] wordCount;

    ring_buffer_uart_tx_if #(.WordSize(WordSize)) rd_if ();

    ring_buffer_uart_tx #(
        .WordSize    (WordSize),
        .ClocksPerBit(ClocksPerBit),
        .StopBits    (StopBits),
        .RetryDelay  (RetryDelay)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rd       (rd_if.master),
        .txOut    (txOut),
        .busy     (busy),
        .wordCount(wordCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [WordSize-1:0] buf_q[$];
    logic [WordSize-1:0] exp_q[$];
    int collide_req    = 0;
    int collide_served = 0;
    int last_gap       = 0;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [WordSize-1:0] word);
        buf_q.push_back(word);
        exp_q.push_back(word);
    endtask

    // Buffer read side: ack/data registered on the REQ edge and sticky after.
    initial begin
        rd_if.dataReadAck = 1'b0;
        rd_if.dataRead    = '0;
    end
    always @(posedge clk) begin
        if (rd_if.dataReadEnable) begin
            if (collide_req != collide_served) begin
                collide_served <= collide_served + 1;
                rd_if.dataReadAck <= 1'b0;
            end else if (buf_q.size() > 0) begin
                rd_if.dataReadAck <= 1'b1;
                rd_if.dataRead    <= buf_q.pop_front();
            end else begin
                rd_if.dataReadAck <= 1'b0;
            end
        end
    end

    // Line monitor
    initial begin
        logic [WordSize+1:0]  frame_bits;
        logic [WordSize-1:0]  w;
        bit                   in_frame;
        bit                   checking;
        int                   cyc;
        int                   high_run;
        in_frame = 0;
        checking = 0;
        cyc      = 0;
        high_run = 0;
        frame_bits = '1;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_frame = 0;
                high_run = 0;
            end else begin
                if (!in_frame) begin
                    if (txOut === 1'b0) begin
                        in_frame = 1;
                        cyc      = 0;
                        last_gap = high_run;
                        if (exp_q.size() == 0) begin
                            check_output("unexpected_frame", 32'd1, 32'd0);
                            checking = 0;
                        end else begin
                            w          = exp_q.pop_front();
                            frame_bits = {1'b1, w, 1'b0};
                            checking   = 1;
                        end
                    end else begin
                        high_run++;
                    end
                end
                if (in_frame) begin
                    if (checking) begin
                        check_output($sformatf("frame_bit%0d", cyc / ClocksPerBit),
                                     {31'd0, txOut}, {31'd0, frame_bits[cyc / ClocksPerBit]});
                        check_output("busy_in_frame", {31'd0, busy}, 32'd1);
                    end
                    cyc++;
                    if (cyc == FrameLen) begin
                        in_frame = 0;
                        high_run = 0;
                    end
                end
            end
        end
    end

    task automatic wait_count(input logic [15:0] target, input int limit,
                              output int pulses);
        int n;
        pulses = 0;
        n      = 0;
        while ((wordCount != target) && (n < limit)) begin
            if (rd_if.dataReadEnable) pulses++;
            @(negedge clk);
            n++;
        end
        if (wordCount != target) check_output("wordcount_timeout", {16'd0, wordCount}, {16'd0, target});
    endtask

    task automatic wait_busy(input int limit);
        int n;
        n = 0;
        while (!busy && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        if (!busy) check_output("busy_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_gap(output int gap);
        int n;
        gap = 0;
        n   = 0;
        while (!rd_if.dataReadEnable && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        do begin
            @(negedge clk);
            gap++;
        end while (!rd_if.dataReadEnable && (gap < 40));
    endtask

    initial begin
        int pulses;
        int gap;
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_txOut", {31'd0, txOut}, 32'd1);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_req", {31'd0, rd_if.dataReadEnable}, 32'd0);
        check_output("reset_wordCount", {16'd0, wordCount}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_output("idle_no_req", {31'd0, rd_if.dataReadEnable}, 32'd0);

        // Single word 0xA5, then empty-buffer retries
        apply_stimulus(8'hA5);
        enable = 1'b1;
        @(negedge clk);
        check_output("req_latency", {31'd0, rd_if.dataReadEnable}, 32'd1);
        wait_count(16'd1, 200, pulses);
        check_output("single_req_pulses", pulses, 32'd1);
        check_output("requeue_after_stop", {31'd0, rd_if.dataReadEnable}, 32'd1);
        pulse_gap(gap);
        check_output("retry_gap_a", gap, 32'd6);
        pulse_gap(gap);
        check_output("retry_gap_b", gap, 32'd6);
        check_output("wordCount_1", {16'd0, wordCount}, 32'd1);
        check_output("retry_busy", {31'd0, busy}, 32'd0);

        // Back-to-back 0x00 then 0xFF
        apply_stimulus(8'h00);
        apply_stimulus(8'hFF);
        wait_count(16'd3, 300, pulses);
        check_output("back_to_back_gap", last_gap, 32'd2);
        pulse_gap(gap);
        check_output("retry_gap_c", gap, 32'd6);
        check_output("wordCount_3", {16'd0, wordCount}, 32'd3);

        // enable dropped mid-DATA
        apply_stimulus(8'h5A);
        wait_busy(50);
        repeat (14) @(negedge clk);
        enable = 1'b0;
        wait_count(16'd4, 200, pulses);
        check_output("idle_after_drop", {31'd0, rd_if.dataReadEnable}, 32'd0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (rd_if.dataReadEnable) pulses++;
        end
        check_output("no_req_when_disabled", pulses, 32'd0);
        check_output("wordCount_4", {16'd0, wordCount}, 32'd4);

        // Asynchronous reset during bit 3 of 0x3C
        apply_stimulus(8'h3C);
        enable = 1'b1;
        wait_busy(50);
        repeat (17) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_txOut", {31'd0, txOut}, 32'd1);
        check_output("async_busy", {31'd0, busy}, 32'd0);
        check_output("async_wordCount", {16'd0, wordCount}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_output("release_no_req", {31'd0, rd_if.dataReadEnable}, 32'd0);
        @(negedge clk);
        check_output("release_req", {31'd0, rd_if.dataReadEnable}, 32'd1);

        // Write-priority collision on top of a stale ack=1
        apply_stimulus(8'h11);
        wait_busy(50);
        collide_req = collide_req + 1;
        apply_stimulus(8'h96);
        wait_count(16'd1, 200, pulses);
        wait_count(16'd2, 300, pulses);
        check_output("collision_req_pulses", pulses, 32'd2);
        check_output("collision_served", collide_served, 32'd1);
        check_output("wordCount_final", {16'd0, wordCount}, 32'd2);

        enable = 1'b0;
        repeat (20) @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end
endmodule
